cci_rd_arbiter: RTL
===================

# cci_rd_arbiter

Round-robin arbiter that shares the CCI channel-0 read-request port (spl_tx_rd_*) among NUM_REQ internal requesters inside fpga_arch and routes channel-0 read responses back to the requester that issued them. It stamps a requester ID into the top bits of the mdata field and enforces CCI almost-full backpressure. It also enforces a global cap on outstanding reads. It sits between the user engines and the top-level CCI ports.

## Interface

- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester-ID width, equal to clog2(NUM_REQ).
- MAX_OUTSTANDING, 64: maximum number of read requests in flight.
- CNT_W, 7: outstanding-counter width; must be at least clog2(MAX_OUTSTANDING+1).

- clk  in  1  CCI interface clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_hdr  in  NUM_REQ*61  per-requester 61-bit CCI read header; requester i occupies slice [61*i+60:61*i].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set.
- cci_tx_rd_almostfull  in  1  channel-0 TX almost full.
- spl_tx_rd_valid  out  1  read request valid to CCI.
- spl_tx_rd_hdr  out  61  read header to CCI.
- cci_rx_rd_valid  in  1  channel-0 read-response valid.
- cci_rx_hdr0  in  18  response header; mdata is [13:0].
- cci_rx_data  in  512  response data.
- resp_valid  out  NUM_REQ  one-hot response valid to the owning requester.
- resp_hdr  out  18  response header, passed through unchanged.
- resp_data  out  512  response data, broadcast to all requesters.
- outstanding  out  CNT_W  current number of reads in flight.
- err_underflow  out  1  sticky flag: a response arrived while outstanding was 0.

## Operation

- can_issue = !cci_tx_rd_almostfull && (outstanding < MAX_OUTSTANDING).
- Grant selection:
  - Combinational, from req_valid.
  - Search starts at rr_ptr and runs upward with wrap-around.
  - The first valid requester wins.
- req_ready[g] = can_issue && req_valid[g], only for the winner g. All other ready bits are 0.
- A request is accepted when req_valid[g] && req_ready[g]. Requesters hold req_valid and req_hdr stable until accepted.
- On accept:
  - The header is registered into the output.
  - Bits [13:14-ID_W] are replaced by g; all other bits pass unchanged.
  - rr_ptr <= (g+1) mod NUM_REQ.
- When no request is accepted, rr_ptr holds its value.
- Requesters must keep their own mdata within [13-ID_W:0]; upper mdata bits they supply are discarded.
- Outstanding counter:
  - +1 on accept.
  - -1 on cci_rx_rd_valid.
  - Both in the same cycle: unchanged.
  - Response with counter at 0: the counter stays at 0 and err_underflow is set. err_underflow clears only on rst.
- Response routing:
  - id = cci_rx_hdr0[13:14-ID_W].
  - On cci_rx_rd_valid, next cycle resp_valid = (1 << id), and resp_hdr/resp_data carry the registered copies of cci_rx_hdr0/cci_rx_data.
  - An id >= NUM_REQ produces no resp_valid bit. The counter still decrements.
- No state machine beyond rr_ptr, the counter and the output registers. The arbiter is fully pipelined: one accept per cycle maximum.

## Timing

- Reset values: spl_tx_rd_valid=0, spl_tx_rd_hdr=0, resp_valid=0, resp_hdr=0, resp_data=0, outstanding=0, err_underflow=0, rr_ptr=0. req_ready=0 while rst is high.
- Request path:
  - Accept in cycle N gives spl_tx_rd_valid=1 in cycle N+1 for exactly one cycle.
  - spl_tx_rd_valid is low in any cycle N+1 that has no accept in cycle N.
- Almost-full:
  - Sampled in the same cycle as the accept decision; when it is high, req_ready is all 0.
  - A request already accepted in the previous cycle still issues. This is one beat of slack, within the CCI almost-full allowance.
- The counter uses its registered value for can_issue. At outstanding = MAX_OUTSTANDING-1, one accept brings it to MAX_OUTSTANDING and the next cycle's ready is 0, unless a response arrives in that same cycle.
- Response latency: exactly 1 cycle from cci_rx_rd_valid to resp_valid.
- Reset mid-operation:
  - All in-flight accounting is discarded.
  - Responses arriving after reset drive err_underflow; the system-level reset ordering prevents this in practice.

## Test plan

- Reset: hold rst 3 cycles with all req_valid=1 -> req_ready=0, spl_tx_rd_valid=0, outstanding=0 throughout; first accept goes to requester 0 on the first cycle after reset.
- Fairness: all 4 requesters continuously valid -> grants 0,1,2,3,0,1… on consecutive cycles; spl_tx_rd_valid high every cycle; hdr[13:12] follows 0,1,2,3.
- Backpressure: almostfull=1 for cycles 5-9 -> no req_ready in cycles 5-9; at most one spl_tx_rd_valid at cycle 5 (from the cycle-4 accept); issue resumes at cycle 10.
- Outstanding cap: MAX_OUTSTANDING=4 with no responses -> exactly 4 issues, then req_ready=0 and outstanding=4. One response -> outstanding=3, one more accept.
- Simultaneous accept and response at outstanding=2 -> outstanding stays 2.
- Routing: response with hdr[13:12]=2 and data=0xA5… -> resp_valid=4'b0100 one cycle later with matching data. A response at outstanding=0 -> err_underflow=1 and stays 1 until rst.

Source files
------------

// File: rtl/cci_rd_arbiter.sv
// ---------------------------------------------------------------------------
// cci_rd_arbiter
//
// Shares the CCI channel-0 read-request port among NUM_REQ internal
// requesters with a round-robin grant. It also steers channel-0 read
// responses back to the requester that issued the read.
//
// The requester ID is stamped into the top ID_W bits of mdata (hdr[13:14-ID_W]).
// Responses are decoded from the same field. Requests are issued only when
// both of these hold:
//   - the CCI TX channel is not almost full;
//   - fewer than MAX_OUTSTANDING reads are in flight.
//
// Ports
//   clk                    interface clock (single domain)
//   rst                    synchronous active-high reset
//   req_valid  [NUM_REQ]   per-requester request valid
//   req_hdr    [NUM_REQ*61] per-requester read header, requester i at [61*i +: 61]
//   req_ready  [NUM_REQ]   per-requester accept, at most one bit set
//   cci_tx_rd_almostfull   channel-0 TX almost full
//   spl_tx_rd_valid/hdr    registered read request to CCI
//   cci_rx_rd_valid/hdr0/data  channel-0 read response from CCI
//   resp_valid [NUM_REQ]   one-hot response valid to the owning requester
//   resp_hdr / resp_data   registered response header/data (data broadcast)
//   outstanding            reads currently in flight
//   err_underflow          sticky: response seen while outstanding was 0
// ---------------------------------------------------------------------------
module cci_rd_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*61-1:0]   req_hdr,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    cci_tx_rd_almostfull,
  output logic                    spl_tx_rd_valid,
  output logic [60:0]             spl_tx_rd_hdr,
  input  logic                    cci_rx_rd_valid,
  input  logic [17:0]             cci_rx_hdr0,
  input  logic [511:0]            cci_rx_data,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [17:0]             resp_hdr,
  output logic [511:0]            resp_data,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    err_underflow
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    grantIdx;
  logic               grantFound;
  logic               canIssue;
  logic               accept;
  logic [60:0]        hdrArr [NUM_REQ];
  logic [60:0]        stampedHdr;
  logic [ID_W-1:0]    rxId;
  logic [NUM_REQ-1:0] respValidNext;

  // Unpack the flat header bus so the winner can be selected by index.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign hdrArr[gi] = req_hdr[61*gi +: 61];
    end
  endgenerate

  // The search starts at rrPtr and wraps around; the first valid requester wins.
  always_comb begin
    int cand;
    cand       = 0;
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rrPtr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grantFound && req_valid[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand[ID_W-1:0];
      end
    end
  end

  // can_issue uses the registered counter. As a result, a request accepted
  // while the counter sits at MAX-1 blocks the following cycle.
  assign canIssue = !cci_tx_rd_almostfull && (outstanding < MaxCnt);
  assign accept   = canIssue && grantFound && !rst;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grantIdx == ID_W'(gi));
    end
  endgenerate

  // Overwrite the top mdata bits with the requester ID. Responses carry
  // these bits back, which lets them be routed.
  always_comb begin
    stampedHdr                 = hdrArr[grantIdx];
    stampedHdr[13 -: ID_W]     = grantIdx;
  end

  // Request path and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      spl_tx_rd_valid <= 1'b0;
      spl_tx_rd_hdr   <= '0;
      rrPtr           <= '0;
    end else begin
      spl_tx_rd_valid <= accept;
      if (accept) begin
        spl_tx_rd_hdr <= stampedHdr;
        rrPtr         <= (int'(grantIdx) == NUM_REQ-1) ? '0 : grantIdx + ID_W'(1);
      end
    end
  end

  // In-flight accounting. When an accept and a response land together, they
  // cancel out. A response that arrives with nothing outstanding cannot
  // belong to any issued read, so it flags underflow and never wraps the
  // counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (cci_rx_rd_valid && outstanding == '0) begin
        err_underflow <= 1'b1;
      end
      case ({accept, cci_rx_rd_valid})
        2'b10:   outstanding <= outstanding + CntOne;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - CntOne;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response routing. An ID that does not match any requester decodes to no
  // valid bit. The counter above still counts that response.
  assign rxId = cci_rx_hdr0[13 -: ID_W];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_route
      assign respValidNext[gi] = cci_rx_rd_valid && (rxId == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= '0;
      resp_hdr   <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= respValidNext;
      if (cci_rx_rd_valid) begin
        resp_hdr  <= cci_rx_hdr0;
        resp_data <= cci_rx_data;
      end
    end
  end

endmodule
